// File: rtl/conv_array_feeder.sv
// conv_array_feeder: loads a 3x3 binary kernel into a PE array, then streams
// one band of 3-bit activation columns, checking the band length against IMG_W.
module conv_array_feeder #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       w_valid,
    output logic       w_ready,
    input  logic [8:0] w_data,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [2:0] a_data,
    input  logic       a_last,
    output logic       weight_control,
    output logic [8:0] weight_in,
    output logic       start,
    output logic [2:0] col_data,
    output logic       col_valid,
    output logic       busy,
    output logic       done,
    output logic       err_len
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ARM    = 2'd2,
        STREAM = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_W - 1);

    state_t           state;
    state_t           state_nxt;
    logic [8:0]       kernel_q;
    logic             wloaded_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       col_data_q;
    logic             col_valid_q;
    logic             done_q;
    logic             err_q;

    // Nothing may advance or be offered while disabled or in reset.
    logic act;
    assign act = en & rst;

    logic at_end;
    assign at_end = (cnt_q == LAST_IDX);

    logic w_ready_c;
    logic a_ready_c;
    logic wctl_c;
    logic start_c;
    logic take_w;
    logic cnt_clr;
    logic cnt_inc;
    logic fwd;
    logic band_ok;
    logic band_err;

    // State register; reset forces IDLE, a disabled cycle keeps the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake and strobe generation.
    always_comb begin
        state_nxt = state;
        w_ready_c = 1'b0;
        a_ready_c = 1'b0;
        wctl_c    = 1'b0;
        start_c   = 1'b0;
        take_w    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        fwd       = 1'b0;
        band_ok   = 1'b0;
        band_err  = 1'b0;
        case (state)
            IDLE: begin
                w_ready_c = act;
                // A new kernel wins over reusing the stored one.
                if (act && w_valid) begin
                    take_w    = 1'b1;
                    state_nxt = LOAD;
                end else if (act && a_valid && wloaded_q) begin
                    state_nxt = ARM;
                end
            end
            LOAD: begin
                wctl_c = act;
                if (act) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                start_c = act;
                cnt_clr = act;
                if (act) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                a_ready_c = act;
                if (act && a_valid) begin
                    if (a_last && at_end) begin
                        fwd       = 1'b1;
                        band_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else if (a_last || at_end) begin
                        band_err  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        fwd     = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Kernel register, reuse flag and band column counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            kernel_q  <= '0;
            wloaded_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (take_w) begin
                kernel_q  <= w_data;
                wloaded_q <= 1'b1;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Registered column path and band-result pulses (latency one cycle).
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_data_q  <= '0;
            col_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            col_valid_q <= fwd;
            done_q      <= band_ok;
            err_q       <= band_err;
            if (fwd) begin
                col_data_q <= a_data;
            end
        end
    end

    // Strobes are masked by enable and reset; data outputs only by reset.
    always_comb begin
        w_ready        = w_ready_c;
        a_ready        = a_ready_c;
        weight_control = wctl_c;
        start          = start_c;
        col_valid      = act & col_valid_q;
        done           = act & done_q;
        err_len        = act & err_q;
        busy           = rst & (state != IDLE);
        weight_in      = rst ? kernel_q : '0;
        col_data       = rst ? col_data_q : '0;
    end

endmodule

// File: tb/tb_conv_array_feeder.sv
// Self-checking bench for conv_array_feeder with IMG_W=4: directed vector
// table, hand-written enable/reset sequences, then randomized traffic checked
// against a band-level reference model.
module tb_conv_array_feeder;

    localparam int IMG_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       w_valid = 1'b0;
    logic [8:0] w_data = '0;
    logic       a_valid = 1'b0;
    logic [2:0] a_data = '0;
    logic       a_last = 1'b0;
    logic       w_ready, a_ready, weight_control, start, col_valid, busy, done, err_len;
    logic [8:0] weight_in;
    logic [2:0] col_data;

    int n_checks = 0;
    int n_errors = 0;

    conv_array_feeder #(.IMG_W(IMG_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .weight_control(weight_control), .weight_in(weight_in), .start(start),
        .col_data(col_data), .col_valid(col_valid), .busy(busy),
        .done(done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_ARM = 2, PH_STREAM = 3;
    int         m_phase = PH_IDLE;
    logic [8:0] m_kernel = '0;
    bit         m_loaded = 0;
    int         m_col = 0;      // columns already taken in this band
    bit         m_cv = 0, m_done = 0, m_err = 0;
    logic [2:0] m_cd = '0;

    function automatic logic [19:0] dut_vec();
        return {w_ready, a_ready, weight_control, weight_in, start,
                col_data, col_valid, busy, done, err_len};
    endfunction

    function automatic logic [19:0] model_vec();
        bit on;
        on = en && rst;
        return {on && m_phase == PH_IDLE, on && m_phase == PH_STREAM,
                on && m_phase == PH_LOAD, rst ? m_kernel : 9'h000,
                on && m_phase == PH_ARM, rst ? m_cd : 3'b000,
                on && m_cv, rst && m_phase != PH_IDLE, on && m_done, on && m_err};
    endfunction

    task automatic model_step();
        bit last_slot;
        if (!rst) begin
            m_phase = PH_IDLE; m_kernel = '0; m_loaded = 0; m_col = 0;
            m_cv = 0; m_done = 0; m_err = 0; m_cd = '0;
            return;
        end
        m_cv = 0; m_done = 0; m_err = 0;
        if (!en) return;
        if (m_phase == PH_IDLE) begin
            if (w_valid) begin
                m_kernel = w_data; m_loaded = 1; m_phase = PH_LOAD;
            end else if (a_valid && m_loaded) begin
                m_phase = PH_ARM;
            end
        end else if (m_phase == PH_LOAD) begin
            m_phase = PH_ARM;
        end else if (m_phase == PH_ARM) begin
            m_col = 0; m_phase = PH_STREAM;
        end else if (a_valid) begin
            last_slot = (m_col + 1 == IMG_W);
            if (last_slot == a_last && !a_last) begin
                m_cv = 1; m_cd = a_data; m_col++;
            end else begin
                m_phase = PH_IDLE;
                if (last_slot && a_last) begin
                    m_cv = 1; m_cd = a_data; m_done = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic show_fail(input string name, input logic [19:0] act, input logic [19:0] req);
        $display("FAIL %s @%0t: got wr=%b ar=%b wc=%b wi=%h st=%b cd=%b cv=%b bz=%b dn=%b er=%b, required wr=%b ar=%b wc=%b wi=%h st=%b cd=%b cv=%b bz=%b dn=%b er=%b",
                 name, $time, act[19], act[18], act[17], act[16:8], act[7], act[6:4], act[3], act[2], act[1], act[0],
                 req[19], req[18], req[17], req[16:8], req[7], req[6:4], req[3], req[2], req[1], req[0]);
    endtask

    task automatic chk_vec(input string name, input logic [19:0] req);
        logic [19:0] act;
        act = dut_vec();
        n_checks++;
        if (act !== req) begin
            n_errors++;
            show_fail(name, act, req);
        end
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b, required %b", name, $time, act, req);
        end
    endtask

    // Model comparison mid-cycle, then the clock edge and model update.
    task automatic run_cycle();
        #1;
        chk_vec("model", model_vec());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic r, input logic e, input logic wv, input logic [8:0] wd,
                          input logic av, input logic [2:0] ad, input logic al);
        rst = r; en = e; w_valid = wv; w_data = wd; a_valid = av; a_data = ad; a_last = al;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst, en, wv;
        logic [8:0] wd;
        logic       av;
        logic [2:0] ad;
        logic       al;
        logic [19:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic r, e, wv, input logic [8:0] wd, input logic av,
                                input logic [2:0] ad, input logic al,
                                input logic wr, ar, wc, input logic [8:0] wi, input logic st,
                                input logic [2:0] cd, input logic cv, bz, dn, er);
        vec_t v;
        v.rst = r; v.en = e; v.wv = wv; v.wd = wd; v.av = av; v.ad = ad; v.al = al;
        v.exp = {wr, ar, wc, wi, st, cd, cv, bz, dn, er};
        return v;
    endfunction

    vec_t tab[25];

    initial begin
        //            rst en wv wd     av ad      al   wr ar wc wi     st cd      cv bz dn er
        tab[0]  = mk(0, 1, 0, 9'h000, 0, 3'b000, 0,   0, 0, 0, 9'h000, 0, 3'b000, 0, 0, 0, 0);
        tab[1]  = mk(1, 1, 1, 9'h1A5, 0, 3'b000, 0,   1, 0, 0, 9'h000, 0, 3'b000, 0, 0, 0, 0);
        tab[2]  = mk(1, 1, 0, 9'h000, 0, 3'b000, 0,   0, 0, 1, 9'h1A5, 0, 3'b000, 0, 1, 0, 0);
        tab[3]  = mk(1, 1, 0, 9'h000, 0, 3'b000, 0,   0, 0, 0, 9'h1A5, 1, 3'b000, 0, 1, 0, 0);
        tab[4]  = mk(1, 1, 0, 9'h000, 1, 3'b001, 0,   0, 1, 0, 9'h1A5, 0, 3'b000, 0, 1, 0, 0);
        tab[5]  = mk(1, 1, 0, 9'h000, 1, 3'b010, 0,   0, 1, 0, 9'h1A5, 0, 3'b001, 1, 1, 0, 0);
        tab[6]  = mk(1, 1, 0, 9'h000, 1, 3'b100, 0,   0, 1, 0, 9'h1A5, 0, 3'b010, 1, 1, 0, 0);
        tab[7]  = mk(1, 1, 0, 9'h000, 1, 3'b111, 1,   0, 1, 0, 9'h1A5, 0, 3'b100, 1, 1, 0, 0);
        tab[8]  = mk(1, 1, 0, 9'h000, 0, 3'b000, 0,   1, 0, 0, 9'h1A5, 0, 3'b111, 1, 0, 1, 0);
        tab[9]  = mk(1, 1, 0, 9'h000, 1, 3'b011, 0,   1, 0, 0, 9'h1A5, 0, 3'b111, 0, 0, 0, 0);
        tab[10] = mk(1, 1, 0, 9'h000, 1, 3'b011, 0,   0, 0, 0, 9'h1A5, 1, 3'b111, 0, 1, 0, 0);
        tab[11] = mk(1, 1, 0, 9'h000, 1, 3'b011, 0,   0, 1, 0, 9'h1A5, 0, 3'b111, 0, 1, 0, 0);
        tab[12] = mk(1, 1, 0, 9'h000, 1, 3'b110, 1,   0, 1, 0, 9'h1A5, 0, 3'b011, 1, 1, 0, 0);
        tab[13] = mk(1, 1, 0, 9'h000, 0, 3'b000, 0,   1, 0, 0, 9'h1A5, 0, 3'b011, 0, 0, 0, 1);
        tab[14] = mk(1, 1, 0, 9'h000, 1, 3'b101, 0,   1, 0, 0, 9'h1A5, 0, 3'b011, 0, 0, 0, 0);
        tab[15] = mk(1, 1, 0, 9'h000, 1, 3'b101, 0,   0, 0, 0, 9'h1A5, 1, 3'b011, 0, 1, 0, 0);
        tab[16] = mk(1, 1, 0, 9'h000, 1, 3'b101, 0,   0, 1, 0, 9'h1A5, 0, 3'b011, 0, 1, 0, 0);
        tab[17] = mk(1, 1, 0, 9'h000, 1, 3'b001, 0,   0, 1, 0, 9'h1A5, 0, 3'b101, 1, 1, 0, 0);
        tab[18] = mk(1, 1, 0, 9'h000, 1, 3'b010, 0,   0, 1, 0, 9'h1A5, 0, 3'b001, 1, 1, 0, 0);
        tab[19] = mk(1, 1, 0, 9'h000, 1, 3'b100, 0,   0, 1, 0, 9'h1A5, 0, 3'b010, 1, 1, 0, 0);
        tab[20] = mk(1, 1, 0, 9'h000, 0, 3'b000, 0,   1, 0, 0, 9'h1A5, 0, 3'b010, 0, 0, 0, 1);
        tab[21] = mk(1, 1, 1, 9'h0F3, 1, 3'b010, 0,   1, 0, 0, 9'h1A5, 0, 3'b010, 0, 0, 0, 0);
        tab[22] = mk(1, 1, 0, 9'h000, 1, 3'b010, 0,   0, 0, 1, 9'h0F3, 0, 3'b010, 0, 1, 0, 0);
        tab[23] = mk(1, 1, 0, 9'h000, 1, 3'b010, 0,   0, 0, 0, 9'h0F3, 1, 3'b010, 0, 1, 0, 0);
        tab[24] = mk(1, 1, 0, 9'h000, 0, 3'b000, 0,   0, 1, 0, 9'h0F3, 0, 3'b010, 0, 1, 0, 0);
    end

    // ---------------- test sequence ----------------
    initial begin
        bit r, e;
        // Initial reset; model variables already hold reset values.
        set_in(0, 0, 0, '0, 0, '0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Directed scenarios: load, reuse, short band, long band, priority.
        for (int unsigned i = 0; i < 25; i++) begin
            set_in(tab[i].rst, tab[i].en, tab[i].wv, tab[i].wd, tab[i].av, tab[i].ad, tab[i].al);
            #1;
            chk_vec($sformatf("tab_row%0d", i), tab[i].exp);
            run_cycle();
        end

        // Enable pause for 3 cycles mid-band; band must still finish cleanly.
        set_in(0, 1, 0, '0, 0, '0, 0); run_cycle();
        set_in(1, 1, 1, 9'h155, 0, '0, 0); run_cycle();
        set_in(1, 1, 0, '0, 0, '0, 0); run_cycle();
        run_cycle();
        set_in(1, 1, 0, '0, 1, 3'b110, 0); run_cycle();
        set_in(1, 1, 0, '0, 1, 3'b011, 0); run_cycle();
        for (int unsigned k = 0; k < 3; k++) begin
            set_in(1, 0, 0, '0, 1, 3'b101, 0);
            #1;
            chk("pause_a_ready", a_ready, 1'b0);
            chk("pause_col_valid", col_valid, 1'b0);
            chk("pause_busy", busy, 1'b1);
            run_cycle();
        end
        set_in(1, 1, 0, '0, 1, 3'b101, 0);
        #1;
        chk("resume_a_ready", a_ready, 1'b1);
        chk("resume_col_valid", col_valid, 1'b0);
        run_cycle();
        set_in(1, 1, 0, '0, 1, 3'b111, 1);
        #1;
        chk("resume_col3_valid", col_valid, 1'b1);
        chk("resume_col3_data", col_data == 3'b101, 1'b1);
        run_cycle();
        set_in(1, 1, 0, '0, 0, '0, 0);
        #1;
        chk("resume_done", done, 1'b1);
        chk("resume_err", err_len, 1'b0);
        chk("resume_col4_data", col_data == 3'b111, 1'b1);
        chk("resume_busy", busy, 1'b0);
        run_cycle();

        // Reset after two columns: band abandoned, stored kernel forgotten.
        set_in(0, 1, 0, '0, 0, '0, 0); run_cycle();
        set_in(1, 1, 1, 9'h0AA, 0, '0, 0); run_cycle();
        set_in(1, 1, 0, '0, 0, '0, 0); run_cycle();
        run_cycle();
        set_in(1, 1, 0, '0, 1, 3'b001, 0); run_cycle();
        set_in(1, 1, 0, '0, 1, 3'b010, 0); run_cycle();
        set_in(0, 1, 0, '0, 1, 3'b100, 0);
        #1;
        chk("rst_outputs_zero", dut_vec() == 20'h0, 1'b1);
        run_cycle();
        for (int unsigned k = 0; k < 3; k++) begin
            set_in(1, 1, 0, '0, 1, 3'b100, 0);
            #1;
            chk("rst_reuse_busy", busy, 1'b0);
            chk("rst_reuse_start", start, 1'b0);
            chk("rst_reuse_done", done, 1'b0);
            chk("rst_reuse_err", err_len, 1'b0);
            chk("rst_reuse_wi", weight_in == 9'h000, 1'b1);
            run_cycle();
        end

        // Randomized traffic against the reference model.
        for (int unsigned n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 9) != 0);
            set_in(r, e, $urandom_range(0, 11) == 0, 9'($urandom),
                   $urandom_range(0, 2) != 0, 3'($urandom),
                   (m_col + 1 == IMG_W) ^ ($urandom_range(0, 7) == 0));
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
